obf_key_loader: RTL

Serial key-delivery controller for the MUX2-camouflaged netlists (`c432` and its siblings). It receives a key frame over a one-bit serial handshake and checks it. It then commits the key atomically to the parallel key bus `s_0..s_{KEY_W-1}` that the locked netlist consumes. Bad frames, stalls and repeated failures drive the bus to a fail-safe all-zero key and can latch a permanent lockout until reset.

---
 rtl/obf_key_pkg.sv | 19 +
 rtl/obf_key_shreg.sv | 58 +++++
 rtl/obf_key_loader.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/obf_key_pkg.sv
// Shared types and constants for the serial key loader.
// Build option: OBF_KEY_PARITY_EN adds a trailing odd-parity bit to each frame.
package obf_key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKOUT = 2'd3
  } obf_key_state_t;

  localparam logic [63:0] OBF_KEY_SAFE = 64'd0;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int OBF_KEY_CNT_W(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// Shadow shift register (MSB first) with running parity over every accepted bit.
// Build option: OBF_KEY_PARITY_EN (the parity bit enters only the running parity).
module obf_key_shreg
  import obf_key_pkg::*;
#(
  parameter int KEY_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             shift,
  input  logic             sdi,
  output logic [KEY_W-1:0] data,
  output logic             par
);

  logic [KEY_W-1:0] data_q, data_d;
  logic             par_q, par_d;
  logic [KEY_W:0]   shifted;

  assign shifted = {data_q, sdi};

  // Next shadow value: clear wins, otherwise accept a bit when enabled.
  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    if (clr) begin
      data_d = '0;
      par_d  = 1'b0;
    end else if (en) begin
      par_d = par_q ^ sdi;
      if (shift) begin
        data_d = shifted[KEY_W-1:0];
      end else begin
        data_d = data_q;
      end
    end else begin
      data_d = data_q;
      par_d  = par_q;
    end
  end

  // Shadow state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign data = data_q;
  assign par  = par_q;

endmodule

// File: rtl/obf_key_loader.sv
// Serial key-frame receiver that atomically commits a verified key or a fail-safe zero key.
// Build option: OBF_KEY_PARITY_EN (frame = KEY_W data bits + one odd-parity bit).
module obf_key_loader
  import obf_key_pkg::*;
#(
  parameter int KEY_W    = 2,
  parameter int TIMEOUT  = 16,
  parameter int MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_valid,
  input  logic             key_sdi,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ok,
  output logic             key_err,
  output logic             key_busy,
  output logic             key_lockout
);

`ifdef OBF_KEY_PARITY_EN
  localparam int FRAME_W = KEY_W + 1;
`else
  localparam int FRAME_W = KEY_W;
`endif
  localparam int BIT_W  = OBF_KEY_CNT_W(KEY_W + 2);
  localparam int IDLE_W = OBF_KEY_CNT_W(TIMEOUT + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX   = BIT_W'(FRAME_W);
  localparam logic [BIT_W-1:0]  BIT_DATA  = BIT_W'(KEY_W);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
  localparam logic [3:0]        FAIL_LAST = 4'(MAX_FAIL - 1);
  localparam logic [KEY_W-1:0]  SAFE_KEY  = OBF_KEY_SAFE[KEY_W-1:0];

  obf_key_state_t    state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [3:0]        fail_cnt_q, fail_cnt_d;
  logic [KEY_W-1:0]  key_out_q, key_out_d;
  logic              key_ok_q, key_ok_d;
  logic              key_err_q, key_err_d;
  logic              key_busy_q, key_busy_d;
  logic              key_lockout_q, key_lockout_d;

  logic             sh_clr, sh_en, sh_shift, sh_par, frame_ok, do_fail;
  logic [KEY_W-1:0] sh_data;

  obf_key_shreg #(.KEY_W(KEY_W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .clr   (sh_clr),
    .en    (sh_en),
    .shift (sh_shift),
    .sdi   (key_sdi),
    .data  (sh_data),
    .par   (sh_par)
  );

  // The trailing parity bit only feeds the running parity, never the key.
  assign sh_shift = (bit_cnt_q < BIT_DATA);

`ifdef OBF_KEY_PARITY_EN
  assign frame_ok = sh_par;
`else
  logic par_unused;
  assign par_unused = sh_par;
  assign frame_ok   = 1'b1;
`endif

  // Frame sequencing, counters and commit/fail decisions.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    fail_cnt_d = fail_cnt_q;
    key_out_d  = key_out_q;
    key_ok_d   = key_ok_q;
    key_err_d  = key_err_q;
    sh_clr     = 1'b0;
    sh_en      = 1'b0;
    do_fail    = 1'b0;

    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (key_start) begin
          state_d    = ST_SHIFT;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          key_err_d  = 1'b0;
          sh_clr     = 1'b1;
        end else if (state_q == ST_SHIFT && key_valid) begin
          sh_en      = 1'b1;
          idle_cnt_d = '0;
          if (bit_cnt_q != BIT_MAX) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (state_q == ST_SHIFT) begin
          if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
          do_fail = (idle_cnt_q == IDLE_LAST);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (frame_ok) begin
          state_d    = ST_IDLE;
          key_out_d  = sh_data;
          key_ok_d   = 1'b1;
          key_err_d  = 1'b0;
          fail_cnt_d = 4'd0;
        end else begin
          do_fail = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        key_out_d = SAFE_KEY;
        key_ok_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (do_fail) begin
      key_out_d = SAFE_KEY;
      key_ok_d  = 1'b0;
      key_err_d = 1'b1;
      if (fail_cnt_q != 4'hF) begin
        fail_cnt_d = fail_cnt_q + 4'd1;
      end else begin
        fail_cnt_d = fail_cnt_q;
      end
      state_d = (fail_cnt_q == FAIL_LAST) ? ST_LOCKOUT : ST_IDLE;
    end else begin
      fail_cnt_d = fail_cnt_d;
    end

    key_busy_d    = (state_d == ST_SHIFT) || (state_d == ST_CHECK);
    key_lockout_d = (state_d == ST_LOCKOUT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      fail_cnt_q    <= 4'd0;
      key_out_q     <= SAFE_KEY;
      key_ok_q      <= 1'b0;
      key_err_q     <= 1'b0;
      key_busy_q    <= 1'b0;
      key_lockout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      fail_cnt_q    <= fail_cnt_d;
      key_out_q     <= key_out_d;
      key_ok_q      <= key_ok_d;
      key_err_q     <= key_err_d;
      key_busy_q    <= key_busy_d;
      key_lockout_q <= key_lockout_d;
    end
  end

  assign key_out     = key_out_q;
  assign key_ok      = key_ok_q;
  assign key_err     = key_err_q;
  assign key_busy    = key_busy_q;
  assign key_lockout = key_lockout_q;

endmodule
